channel_update_scheduler: RTL and testbench
===========================================

# channel_update_scheduler

Sequences configuration commands from `mcu_interface` into the two DDS signal channels, so that updates never tear a waveform period and never collide on the shared phase-update path. Single-cycle control strobes are latched as pending requests. Step-register loads are deferred to the target channel's next phase-accumulator wrap, or to a timeout. Eligible commands are issued one per clock through a fixed-priority / round-robin arbiter. The block sits between `mcu_interface` and the channel phase-accumulator cores.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1250000: clocks a load-step request waits for a wrap before being forced (10 ms at 125 MHz); must be ≥ 2.
- `TIMEOUT_WIDTH`, 21: width of each timeout counter; must hold `TIMEOUT_CYCLES-1`.

Ports:
- `i_main_clk`  in  1  main clock, 125 MHz; the only clock.
- `i_reset`  in  1  reset, synchronous, active-high.
- `i_load_channel1_step_registers`  in  1  single-cycle request strobe.
- `i_add_channel1_signal_phase`  in  1  single-cycle request strobe.
- `i_load_channel2_step_registers`  in  1  single-cycle request strobe.
- `i_add_channel2_signal_phase`  in  1  single-cycle request strobe.
- `i_reset_signal_phase_registers`  in  1  single-cycle global request strobe.
- `i_channel1_wrap`  in  1  one-cycle pulse from channel 1 accumulator on wrap.
- `i_channel2_wrap`  in  1  one-cycle pulse from channel 2 accumulator on wrap.
- `o_channel1_load_step`  out  1  command pulse to channel 1.
- `o_channel1_add_phase`  out  1  command pulse to channel 1.
- `o_channel2_load_step`  out  1  command pulse to channel 2.
- `o_channel2_add_phase`  out  1  command pulse to channel 2.
- `o_reset_phase`  out  1  command pulse to both channels.
- `o_busy`  out  1  high while any request is pending.
- `o_request_merged`  out  1  one-cycle pulse when a request hits an already-pending request of the same kind.

## Operation
- Five pending bits:
  - per channel: `load_pend` and `add_pend`
  - global: `rst_pend`
- A request strobe sets its bit.
- If the bit is already set, the request merges: no second command is issued, and `o_request_merged` pulses.
- Eligibility:
  - `add_pend` and `rst_pend` are eligible immediately.
  - `load_pend` is eligible after a wrap pulse on its channel sampled on a later edge than the request, or when its timeout counter reaches `TIMEOUT_CYCLES-1`, whichever comes first.
  - A wrap coincident with the request edge does not count.
- Per-channel load FSM:
  - IDLE → WAIT_WRAP on request, counter cleared to 0.
  - WAIT_WRAP → READY on qualifying wrap or timeout. The counter increments each clock in WAIT_WRAP.
  - READY → IDLE when granted.
  - A merged request in WAIT_WRAP or READY does not restart the counter.
- Arbiter issues at most one command per clock, so the outputs are one-hot or zero.
  - Priority 1: `rst_pend`.
  - Priority 2: channel round-robin pointer. Start at channel 1; after any channel grant, the pointer moves to the other channel.
  - Within the selected channel, load_step wins over add_phase.
  - If the selected channel has nothing eligible, the other channel is served.
- When reset_phase is granted, it clears both `add_pend` bits, including add requests sampled on the same edge. `load_pend` and load FSMs are unaffected.
- Granting a command clears its pending bit. A new request for that same kind sampled on the grant edge re-sets the bit and does not merge.
- `o_busy` = OR of all pending bits.

## Timing
- All outputs are registered; every output resets to 0.
- `i_reset` clears:
  - all pending bits and FSMs (to IDLE)
  - the counters
  - the round-robin pointer (to channel 1)
- Strobes sampled while `i_reset` is high are discarded. Reset takes effect mid-wait, dropping pending loads.
- Latency, uncontended add or reset request sampled on edge k: command high for the clock following edge k+1.
- Latency, load with wrap sampled on edge w > request edge: command after edge w+1.
- Latency, load without wrap: command after edge r+`TIMEOUT_CYCLES`+1.
- Each command pulse lasts exactly one clock.
- `o_request_merged` is asserted after the edge that sampled the merging strobe.

## Structure
- Shared include `signal_generator_defines.vh`: default `TIMEOUT_CYCLES`, load-FSM state encodings (IDLE/WAIT_WRAP/READY), command index constants.
- One sub-module, `channel_update_slot`, instantiated once per channel: load FSM, timeout counter, `add_pend`, merge detect, eligibility outputs.
- The top level holds `rst_pend`, the arbiter, the round-robin pointer, and the output registers.

## Test plan
Bench uses `TIMEOUT_CYCLES`=16.
- Add ch1 strobe at edge 10, no other traffic → `o_channel1_add_phase` high one clock after edge 11, `o_busy` low after edge 11.
- Load ch2 at edge 5, `i_channel2_wrap` at edges 5 and 9 → edge-5 wrap ignored; `o_channel2_load_step` after edge 10.
- Load ch1 at edge 0, no wrap → command after edge 17; second load strobe at edge 3 → `o_request_merged` after edge 3, still one command.
- Add ch1, add ch2, and reset strobes all at edge 20 → only `o_reset_phase` after edge 21; both adds cleared; `o_busy` low after edge 21.
- Load ch1 ready plus add ch1 and add ch2 pending, pointer at ch1 → grants in order ch1 load, ch2 add, ch1 add on consecutive clocks.
- Load ch2 pending in WAIT_WRAP, `i_reset` at edge 8 → no command ever issued; all outputs 0 after edge 8.

Source files
------------

// File: rtl/channel_update_scheduler_pkg.sv
// Shared constants for the channel update scheduler: default timing,
// load-FSM state encoding and command bit positions.
package channel_update_scheduler_pkg;

    localparam int TIMEOUT_CYCLES_DEFAULT = 1250000;
    localparam int TIMEOUT_WIDTH_DEFAULT  = 21;

    typedef enum logic [1:0] {
        LS_IDLE      = 2'd0,
        LS_WAIT_WRAP = 2'd1,
        LS_READY     = 2'd2
    } load_state_t;

    localparam int CMD_CH1_LOAD  = 0;
    localparam int CMD_CH1_ADD   = 1;
    localparam int CMD_CH2_LOAD  = 2;
    localparam int CMD_CH2_ADD   = 3;
    localparam int CMD_RST_PHASE = 4;
    localparam int CMD_W         = 5;

endpackage

// File: rtl/channel_update_scheduler_if.sv
// Request/command bundle between mcu_interface, the scheduler and the
// two channel phase-accumulator cores.
interface channel_update_scheduler_if;
    logic i_load_channel1_step_registers;
    logic i_add_channel1_signal_phase;
    logic i_load_channel2_step_registers;
    logic i_add_channel2_signal_phase;
    logic i_reset_signal_phase_registers;
    logic i_channel1_wrap;
    logic i_channel2_wrap;
    logic o_channel1_load_step;
    logic o_channel1_add_phase;
    logic o_channel2_load_step;
    logic o_channel2_add_phase;
    logic o_reset_phase;
    logic o_busy;
    logic o_request_merged;

    modport master (
        output i_load_channel1_step_registers, i_add_channel1_signal_phase,
               i_load_channel2_step_registers, i_add_channel2_signal_phase,
               i_reset_signal_phase_registers, i_channel1_wrap, i_channel2_wrap,
        input  o_channel1_load_step, o_channel1_add_phase, o_channel2_load_step,
               o_channel2_add_phase, o_reset_phase, o_busy, o_request_merged
    );

    modport slave (
        input  i_load_channel1_step_registers, i_add_channel1_signal_phase,
               i_load_channel2_step_registers, i_add_channel2_signal_phase,
               i_reset_signal_phase_registers, i_channel1_wrap, i_channel2_wrap,
        output o_channel1_load_step, o_channel1_add_phase, o_channel2_load_step,
               o_channel2_add_phase, o_reset_phase, o_busy, o_request_merged
    );
endinterface

// File: rtl/channel_update_scheduler_slot.sv
// Per-channel request state: load FSM with wrap/timeout qualification,
// pending add bit, and same-kind merge detection.
module channel_update_slot
    import channel_update_scheduler_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int TIMEOUT_WIDTH  = TIMEOUT_WIDTH_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load_req,
    input  logic i_add_req,
    input  logic i_wrap,
    input  logic i_grant_load,
    input  logic i_grant_add,
    input  logic i_clear_add,
    output logic o_load_elig,
    output logic o_load_pend,
    output logic o_add_pend,
    output logic o_merged
);
    localparam logic [TIMEOUT_WIDTH-1:0] LP_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    load_state_t              r_state;
    logic [TIMEOUT_WIDTH-1:0] r_cnt;
    logic                     r_add_pend;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= LS_IDLE;
            r_cnt      <= '0;
            r_add_pend <= 1'b0;
        end else begin
            case (r_state)
                LS_IDLE: begin
                    if (i_load_req) begin
                        r_state <= LS_WAIT_WRAP;
                        r_cnt   <= '0;
                    end
                end
                // A wrap on the request edge never reaches here: the FSM is still IDLE then.
                LS_WAIT_WRAP: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (i_wrap || r_cnt == LP_LAST) r_state <= LS_READY;
                end
                LS_READY: begin
                    if (i_grant_load) begin
                        if (i_load_req) begin
                            r_state <= LS_WAIT_WRAP;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= LS_IDLE;
                        end
                    end
                end
                default: r_state <= LS_IDLE;
            endcase

            if (i_clear_add)      r_add_pend <= 1'b0;
            else if (i_add_req)   r_add_pend <= 1'b1;
            else if (i_grant_add) r_add_pend <= 1'b0;
        end
    end

    assign o_load_elig = (r_state == LS_READY);
    assign o_load_pend = (r_state != LS_IDLE);
    assign o_add_pend  = r_add_pend;
    // A request landing on its own grant edge re-arms rather than merges.
    assign o_merged    = (i_load_req && (r_state != LS_IDLE) && !i_grant_load)
                       || (i_add_req && r_add_pend && !i_grant_add);
endmodule

// File: rtl/channel_update_scheduler.sv
// Latches configuration strobes and issues at most one channel command per
// clock: phase reset first, then round-robin between the two channels.
module channel_update_scheduler
    import channel_update_scheduler_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int TIMEOUT_WIDTH  = TIMEOUT_WIDTH_DEFAULT
) (
    input logic                         i_main_clk,
    input logic                         i_reset,
    channel_update_scheduler_if.slave   bus
);
    logic [1:0]       w_load_req, w_add_req, w_wrap;
    logic [1:0]       w_load_elig, w_load_pend, w_add_pend, w_merged;
    logic [1:0]       w_grant_load, w_grant_add, w_chan_elig;
    logic             w_grant_rst, w_sel, w_rst_merge;
    logic [CMD_W-1:0] w_cmd;
    logic [CMD_W-1:0] r_cmd;
    logic             r_rst_pend, r_ptr, r_merged;

    assign w_load_req = {bus.i_load_channel2_step_registers, bus.i_load_channel1_step_registers};
    assign w_add_req  = {bus.i_add_channel2_signal_phase, bus.i_add_channel1_signal_phase};
    assign w_wrap     = {bus.i_channel2_wrap, bus.i_channel1_wrap};

    for (genvar g = 0; g < 2; g++) begin : g_slot
        channel_update_slot #(
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
            .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
        ) u_slot (
            .i_clk        (i_main_clk),
            .i_rst        (i_reset),
            .i_load_req   (w_load_req[g]),
            .i_add_req    (w_add_req[g]),
            .i_wrap       (w_wrap[g]),
            .i_grant_load (w_grant_load[g]),
            .i_grant_add  (w_grant_add[g]),
            .i_clear_add  (w_grant_rst),
            .o_load_elig  (w_load_elig[g]),
            .o_load_pend  (w_load_pend[g]),
            .o_add_pend   (w_add_pend[g]),
            .o_merged     (w_merged[g])
        );
    end

    assign w_chan_elig = w_load_elig | w_add_pend;

    always_comb begin
        w_grant_load = '0;
        w_grant_add  = '0;
        w_grant_rst  = 1'b0;
        w_sel        = r_ptr;
        if (r_rst_pend) begin
            w_grant_rst = 1'b1;
        end else begin
            if (!w_chan_elig[r_ptr]) w_sel = ~r_ptr;
            if (w_load_elig[w_sel])     w_grant_load[w_sel] = 1'b1;
            else if (w_add_pend[w_sel]) w_grant_add[w_sel]  = 1'b1;
        end
    end

    always_comb begin
        w_cmd                = '0;
        w_cmd[CMD_CH1_LOAD]  = w_grant_load[0];
        w_cmd[CMD_CH1_ADD]   = w_grant_add[0];
        w_cmd[CMD_CH2_LOAD]  = w_grant_load[1];
        w_cmd[CMD_CH2_ADD]   = w_grant_add[1];
        w_cmd[CMD_RST_PHASE] = w_grant_rst;
    end

    assign w_rst_merge = bus.i_reset_signal_phase_registers && r_rst_pend && !w_grant_rst;

    always_ff @(posedge i_main_clk) begin
        if (i_reset) begin
            r_cmd      <= '0;
            r_rst_pend <= 1'b0;
            r_ptr      <= 1'b0;
            r_merged   <= 1'b0;
        end else begin
            r_cmd    <= w_cmd;
            r_merged <= w_rst_merge | (|w_merged);
            if (bus.i_reset_signal_phase_registers) r_rst_pend <= 1'b1;
            else if (w_grant_rst)                   r_rst_pend <= 1'b0;
            if (|(w_grant_load | w_grant_add))      r_ptr      <= ~w_sel;
        end
    end

    assign bus.o_channel1_load_step = r_cmd[CMD_CH1_LOAD];
    assign bus.o_channel1_add_phase = r_cmd[CMD_CH1_ADD];
    assign bus.o_channel2_load_step = r_cmd[CMD_CH2_LOAD];
    assign bus.o_channel2_add_phase = r_cmd[CMD_CH2_ADD];
    assign bus.o_reset_phase        = r_cmd[CMD_RST_PHASE];
    assign bus.o_busy               = r_rst_pend | (|w_load_pend) | (|w_add_pend);
    assign bus.o_request_merged     = r_merged;
endmodule

// File: tb/tb_channel_update_scheduler.sv
// Directed bench for channel_update_scheduler with TIMEOUT_CYCLES = 16.
module tb_channel_update_scheduler;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    channel_update_scheduler_if bus ();

    channel_update_scheduler #(
        .TIMEOUT_CYCLES (16),
        .TIMEOUT_WIDTH  (5)
    ) dut (
        .i_main_clk (clk),
        .i_reset    (rst),
        .bus        (bus)
    );

    // {c1_load, c1_add, c2_load, c2_add, reset_phase, busy, merged}
    logic [6:0] obs;
    assign obs = {bus.o_channel1_load_step, bus.o_channel1_add_phase,
                  bus.o_channel2_load_step, bus.o_channel2_add_phase,
                  bus.o_reset_phase, bus.o_busy, bus.o_request_merged};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_load_channel1_step_registers = 1'b0;
        bus.i_add_channel1_signal_phase    = 1'b0;
        bus.i_load_channel2_step_registers = 1'b0;
        bus.i_add_channel2_signal_phase    = 1'b0;
        bus.i_reset_signal_phase_registers = 1'b0;
        bus.i_channel1_wrap                = 1'b0;
        bus.i_channel2_wrap                = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        total++;
        if (obs !== 7'b0000000) begin
            bad++;
            $display("FAIL reset_state got=%b want=%b", obs, 7'b0000000);
        end
        rst = 1'b0;
        step();
        total++;
        if (obs !== 7'b0000000) begin
            bad++;
            $display("FAIL reset_release got=%b want=%b", obs, 7'b0000000);
        end
    endtask

    task automatic test_add();
        logic [6:0] exp;
        for (int k = 0; k <= 2; k++) begin
            bus.i_add_channel1_signal_phase = (k == 0);
            step();
            clear_inputs();
            exp = (k == 0) ? 7'b0000010 : (k == 1) ? 7'b0100000 : 7'b0000000;
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL add_ch1 cyc=%0d got=%b want=%b", k, obs, exp);
            end
        end
    endtask

    task automatic test_load_wrap();
        logic [6:0] exp;
        for (int k = 0; k <= 6; k++) begin
            bus.i_load_channel2_step_registers = (k == 0);
            bus.i_channel2_wrap                = (k == 0) || (k == 4);
            step();
            clear_inputs();
            exp = (k <= 4) ? 7'b0000010 : (k == 5) ? 7'b0010000 : 7'b0000000;
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL load_wrap_ch2 cyc=%0d got=%b want=%b", k, obs, exp);
            end
        end
    endtask

    task automatic test_load_timeout();
        logic [6:0] exp;
        int ncmd;
        ncmd = 0;
        for (int k = 0; k <= 19; k++) begin
            bus.i_load_channel1_step_registers = (k == 0) || (k == 3);
            step();
            clear_inputs();
            if (k == 17)      exp = 7'b1000000;
            else if (k >= 18) exp = 7'b0000000;
            else if (k == 3)  exp = 7'b0000011;
            else              exp = 7'b0000010;
            ncmd += int'(obs[6]);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL load_timeout_ch1 cyc=%0d got=%b want=%b", k, obs, exp);
            end
        end
        total++;
        if (ncmd != 1) begin
            bad++;
            $display("FAIL load_timeout_count got=%0d want=1", ncmd);
        end
    endtask

    task automatic test_reset_priority();
        logic [6:0] exp;
        for (int k = 0; k <= 3; k++) begin
            bus.i_add_channel1_signal_phase    = (k == 0);
            bus.i_add_channel2_signal_phase    = (k == 0);
            bus.i_reset_signal_phase_registers = (k == 0);
            step();
            clear_inputs();
            exp = (k == 0) ? 7'b0000010 : (k == 1) ? 7'b0000100 : 7'b0000000;
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL reset_priority cyc=%0d got=%b want=%b", k, obs, exp);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [6:0] exp;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            bus.i_load_channel1_step_registers = (k == 0);
            bus.i_channel1_wrap                = (k == 1);
            bus.i_add_channel1_signal_phase    = (k == 1);
            bus.i_add_channel2_signal_phase    = (k == 1);
            step();
            clear_inputs();
            case (k)
                0, 1:    exp = 7'b0000010;
                2:       exp = 7'b1000010;
                3:       exp = 7'b0001010;
                4:       exp = 7'b0100000;
                default: exp = 7'b0000000;
            endcase
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL round_robin cyc=%0d got=%b want=%b", k, obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp;
        for (int k = 0; k <= 3; k++) begin
            bus.i_add_channel2_signal_phase = (k <= 1);
            step();
            clear_inputs();
            case (k)
                0:       exp = 7'b0000010;
                1:       exp = 7'b0001010;
                2:       exp = 7'b0001000;
                default: exp = 7'b0000000;
            endcase
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL back_to_back_add cyc=%0d got=%b want=%b", k, obs, exp);
            end
        end
    endtask

    task automatic test_reset_midwait();
        logic [6:0] exp;
        int ncmd;
        ncmd = 0;
        for (int k = 0; k <= 30; k++) begin
            bus.i_load_channel2_step_registers = (k == 0);
            bus.i_add_channel1_signal_phase    = (k == 8);
            bus.i_channel2_wrap                = (k == 10);
            rst = (k == 8);
            step();
            clear_inputs();
            rst = 1'b0;
            exp = (k < 8) ? 7'b0000010 : 7'b0000000;
            ncmd += int'(|obs[6:2]);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL reset_midwait cyc=%0d got=%b want=%b", k, obs, exp);
            end
        end
        total++;
        if (ncmd != 0) begin
            bad++;
            $display("FAIL reset_midwait_cmds got=%0d want=0", ncmd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        clear_inputs();
        test_reset();
        test_add();
        test_load_wrap();
        test_load_timeout();
        test_reset_priority();
        test_round_robin();
        test_back_to_back();
        test_reset_midwait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
